// File: rtl/alu_8bit_pkg.sv
// Shared definitions for the 8-bit ALU: default width, opcode encodings and
// the adder/subtractor mode select.
package alu_8bit_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int OPCODE_W      = 5;

  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_ADDC = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd2;
  localparam logic [OPCODE_W-1:0] OP_SUBB = 5'd3;
  localparam logic [OPCODE_W-1:0] OP_PASA = 5'd4;
  localparam logic [OPCODE_W-1:0] OP_INR  = 5'd5;
  localparam logic [OPCODE_W-1:0] OP_DCR  = 5'd6;
  localparam logic [OPCODE_W-1:0] OP_NEG  = 5'd7;
  localparam logic [OPCODE_W-1:0] OP_AND  = 5'd8;
  localparam logic [OPCODE_W-1:0] OP_OR   = 5'd9;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 5'd10;
  localparam logic [OPCODE_W-1:0] OP_CMA  = 5'd11;
  localparam logic [OPCODE_W-1:0] OP_SHL  = 5'd12;
  localparam logic [OPCODE_W-1:0] OP_SHR  = 5'd13;
  localparam logic [OPCODE_W-1:0] OP_SAR  = 5'd14;
  localparam logic [OPCODE_W-1:0] OP_PASB = 5'd15;
  localparam logic [OPCODE_W-1:0] OP_RLC  = 5'd16;
  localparam logic [OPCODE_W-1:0] OP_RRC  = 5'd17;
  localparam logic [OPCODE_W-1:0] OP_RAL  = 5'd18;
  localparam logic [OPCODE_W-1:0] OP_RAR  = 5'd19;

  typedef enum logic {
    ADDSUB_ADD = 1'b0,
    ADDSUB_SUB = 1'b1
  } addsub_mode_e;

  // Ops whose overflow flag comes from the shared adder; everything else reports 0.
  function automatic logic op_has_overflow(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_ADDC) || (op == OP_SUB) ||
           (op == OP_SUBB) || (op == OP_INR) || (op == OP_DCR);
  endfunction

endpackage

// File: rtl/alu_8bit_if.sv
// Operand/result bus between the CPU datapath (master) and the ALU (slave).
interface alu_8bit_if
  import alu_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [OPCODE_W-1:0] opcode;
  logic [WIDTH-1:0]    operand_A;
  logic [WIDTH-1:0]    operand_B;
  logic                enable;
  logic                input_ready;
  logic                carry_in;
  logic                borrow_in;
  logic [WIDTH-1:0]    result_out;
  logic                carry_out;
  logic                borrow_out;
  logic                result_ready;
  logic                zero;
  logic                negative;
  logic                overflow;

  modport master (
    output opcode, operand_A, operand_B, enable, input_ready, carry_in, borrow_in,
    input  result_out, carry_out, borrow_out, result_ready, zero, negative, overflow
  );

  modport slave (
    input  opcode, operand_A, operand_B, enable, input_ready, carry_in, borrow_in,
    output result_out, carry_out, borrow_out, result_ready, zero, negative, overflow
  );

endinterface

// File: rtl/alu_8bit_addsub.sv
// Shared WIDTH+1 bit adder/subtractor; bit WIDTH is carry (add) or borrow (sub).
module alu_8bit_addsub
  import alu_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  addsub_mode_e     mode,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);

  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;
  logic [WIDTH:0] ext_c;

  assign ext_a = {1'b0, a};
  assign ext_b = {1'b0, b};
  assign ext_c = {{WIDTH{1'b0}}, cin};

  // In subtract mode cin is the incoming borrow, so the upper bit is the outgoing borrow.
  always_comb begin
    sum      = '0;
    overflow = 1'b0;
    if (mode == ADDSUB_SUB) begin
      sum      = ext_a - ext_b - ext_c;
      overflow = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      sum      = ext_a + ext_b + ext_c;
      overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/alu_8bit.sv
// Registered ALU: one combinational op decode feeding a single result/flag register.
module alu_8bit
  import alu_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  alu_8bit_if.slave  bus
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             bin;

  logic [WIDTH-1:0] as_a;
  logic [WIDTH-1:0] as_b;
  logic             as_cin;
  addsub_mode_e     as_mode;
  logic [WIDTH:0]   as_sum;
  logic             as_ovf;

  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic             nxt_borrow;
  logic             nxt_overflow;

  assign a   = bus.operand_A;
  assign b   = bus.operand_B;
  assign cin = bus.carry_in;
  assign bin = bus.borrow_in;

  // All arithmetic ops share one adder; INR/DCR use a constant 1, NEG computes 0 - A.
  always_comb begin
    as_a    = a;
    as_b    = b;
    as_cin  = 1'b0;
    as_mode = ADDSUB_ADD;
    case (bus.opcode)
      OP_ADDC: as_cin = cin;
      OP_SUB:  as_mode = ADDSUB_SUB;
      OP_SUBB: begin
        as_mode = ADDSUB_SUB;
        as_cin  = bin;
      end
      OP_INR:  as_b = WIDTH'(1);
      OP_DCR:  begin
        as_b    = WIDTH'(1);
        as_mode = ADDSUB_SUB;
      end
      OP_NEG:  begin
        as_a    = '0;
        as_b    = a;
        as_mode = ADDSUB_SUB;
      end
      default: ;
    endcase
  end

  alu_8bit_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (as_a),
    .b        (as_b),
    .cin      (as_cin),
    .mode     (as_mode),
    .sum      (as_sum),
    .overflow (as_ovf)
  );

  always_comb begin
    nxt_result   = '0;
    nxt_carry    = cin;
    nxt_borrow   = bin;
    nxt_overflow = op_has_overflow(bus.opcode) ? as_ovf : 1'b0;
    case (bus.opcode)
      OP_ADD, OP_ADDC: begin
        nxt_result = as_sum[WIDTH-1:0];
        nxt_carry  = as_sum[WIDTH];
      end
      OP_SUB, OP_SUBB, OP_NEG: begin
        nxt_result = as_sum[WIDTH-1:0];
        nxt_borrow = as_sum[WIDTH];
      end
      OP_INR, OP_DCR: nxt_result = as_sum[WIDTH-1:0];
      OP_PASA: nxt_result = a;
      OP_AND: begin
        nxt_result = a & b;
        nxt_carry  = 1'b0;
      end
      OP_OR: begin
        nxt_result = a | b;
        nxt_carry  = 1'b0;
      end
      OP_XOR: begin
        nxt_result = a ^ b;
        nxt_carry  = 1'b0;
      end
      OP_CMA:  nxt_result = ~a;
      OP_SHL: begin
        nxt_result = {a[WIDTH-2:0], 1'b0};
        nxt_carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        nxt_result = {1'b0, a[WIDTH-1:1]};
        nxt_carry  = a[0];
      end
      OP_SAR: begin
        nxt_result = {a[WIDTH-1], a[WIDTH-1:1]};
        nxt_carry  = a[0];
      end
      OP_PASB: nxt_result = b;
      OP_RLC: begin
        nxt_result = {a[WIDTH-2:0], a[WIDTH-1]};
        nxt_carry  = a[WIDTH-1];
      end
      OP_RRC: begin
        nxt_result = {a[0], a[WIDTH-1:1]};
        nxt_carry  = a[0];
      end
      OP_RAL: begin
        nxt_result = {a[WIDTH-2:0], cin};
        nxt_carry  = a[WIDTH-1];
      end
      OP_RAR: begin
        nxt_result = {cin, a[WIDTH-1:1]};
        nxt_carry  = a[0];
      end
      default: ;
    endcase
  end

  // zero/negative are derived from the new result so all flags update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result_out   <= '0;
      bus.carry_out    <= 1'b0;
      bus.borrow_out   <= 1'b0;
      bus.result_ready <= 1'b0;
      bus.zero         <= 1'b0;
      bus.negative     <= 1'b0;
      bus.overflow     <= 1'b0;
    end else begin
      bus.result_ready <= bus.enable & bus.input_ready;
      if (bus.enable) begin
        bus.result_out <= nxt_result;
        bus.carry_out  <= nxt_carry;
        bus.borrow_out <= nxt_borrow;
        bus.zero       <= (nxt_result == '0);
        bus.negative   <= nxt_result[WIDTH-1];
        bus.overflow   <= nxt_overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: directed vectors push expectations, a monitor
// compares whenever result_ready is seen.
module tb_alu_8bit;
  import alu_8bit_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic       cout;
    logic       bout;
    logic       zero;
    logic       neg;
    logic       ovf;
  } exp_t;

  typedef struct packed {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       bin;
    exp_t       exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sbQueue[$];
  vec_t vecQ[$];
  exp_t lastExp;

  alu_8bit_if #(.WIDTH(8)) bus ();

  alu_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t currentOutputs();
    return {bus.result_out, bus.carry_out, bus.borrow_out, bus.zero, bus.negative, bus.overflow};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  task automatic addVec(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic bin, input logic [7:0] res,
                        input logic cout, input logic bout, input logic z,
                        input logic n, input logic v);
    vec_t t;
    t.op  = op;
    t.a   = a;
    t.b   = b;
    t.cin = cin;
    t.bin = bin;
    t.exp = '{res: res, cout: cout, bout: bout, zero: z, neg: n, ovf: v};
    vecQ.push_back(t);
  endtask

  // Drive one op with a single-cycle strobe, then drop enable so results hold.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.opcode      = v.op;
    bus.operand_A   = v.a;
    bus.operand_B   = v.b;
    bus.carry_in    = v.cin;
    bus.borrow_in   = v.bin;
    bus.enable      = 1'b1;
    bus.input_ready = 1'b1;
    sbQueue.push_back(v.exp);
    @(negedge clk);
    bus.enable      = 1'b0;
    bus.input_ready = 1'b0;
  endtask

  // Monitor: samples shortly after each rising edge.
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #2;
      if (bus.result_ready === 1'b1) begin
        checks++;
        g = currentOutputs();
        if (sbQueue.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_ready: got result_ready=1 with outputs 0x%0h, expected no response", g);
        end else begin
          e = sbQueue.pop_front();
          if (g !== e) begin
            errors++;
            $display("[TB] FAIL scoreboard: got res=%02h c=%b b=%b z=%b n=%b v=%b expected res=%02h c=%b b=%b z=%b n=%b v=%b",
                     g.res, g.cout, g.bout, g.zero, g.neg, g.ovf,
                     e.res, e.cout, e.bout, e.zero, e.neg, e.ovf);
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;

    //      op       A      B      cin   bin   res    cout  bout  z     n     v
    addVec(OP_ADD,  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    addVec(OP_ADD,  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    addVec(OP_SUB,  8'h02, 8'h05, 1'b0, 1'b0, 8'hFD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    addVec(OP_SUBB, 8'h05, 8'h02, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(OP_RAL,  8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(OP_RRC,  8'h01, 8'h00, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    addVec(OP_CMA,  8'h0F, 8'h00, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    addVec(OP_ADDC, 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(OP_INR,  8'h7F, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    addVec(OP_DCR,  8'h80, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    addVec(OP_NEG,  8'h05, 8'h00, 1'b0, 1'b0, 8'hFB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    addVec(OP_AND,  8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(OP_OR,   8'h0A, 8'h50, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(OP_XOR,  8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    addVec(OP_PASA, 8'h00, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    addVec(OP_SHL,  8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(OP_SHR,  8'h81, 8'h00, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(OP_SAR,  8'h81, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    addVec(OP_PASB, 8'h00, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    addVec(OP_RLC,  8'h80, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(OP_RAR,  8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    addVec(5'd25,   8'h12, 8'h34, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    addVec(OP_SUB,  8'h7F, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset held with an active strobe: reset must win.
    rst             = 1'b1;
    bus.opcode      = OP_ADD;
    bus.operand_A   = 8'hFF;
    bus.operand_B   = 8'h01;
    bus.carry_in    = 1'b1;
    bus.borrow_in   = 1'b1;
    bus.enable      = 1'b1;
    bus.input_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_outputs", {3'b0, currentOutputs()}, 16'h0000);
    checkOutput("reset_ready", {15'b0, bus.result_ready}, 16'h0000);
    rst             = 1'b0;
    bus.enable      = 1'b0;
    bus.input_ready = 1'b0;

    // Pulse shape on the first vector: high one cycle after the strobe, then low.
    applyStimulus(vecQ[0]);
    checkOutput("ready_pulse_high", {15'b0, bus.result_ready}, 16'h0001);
    @(negedge clk);
    checkOutput("ready_pulse_low", {15'b0, bus.result_ready}, 16'h0000);

    for (int i = 1; i < vecQ.size(); i++) begin
      applyStimulus(vecQ[i]);
    end
    lastExp = vecQ[vecQ.size()-1].exp;

    // enable low with fresh operands and a strobe: everything holds, no ready.
    @(negedge clk);
    bus.opcode      = OP_ADD;
    bus.operand_A   = 8'h01;
    bus.operand_B   = 8'h01;
    bus.carry_in    = 1'b0;
    bus.borrow_in   = 1'b0;
    bus.enable      = 1'b0;
    bus.input_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_outputs", {3'b0, currentOutputs()}, {3'b0, lastExp});
    checkOutput("hold_ready", {15'b0, bus.result_ready}, 16'h0000);
    bus.input_ready = 1'b0;

    // Mid-run reset clears nonzero state.
    @(negedge clk);
    rst             = 1'b1;
    bus.enable      = 1'b1;
    bus.input_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrun_reset", {2'b0, currentOutputs(), bus.result_ready}, 16'h0000);
    rst             = 1'b0;
    bus.enable      = 1'b0;
    bus.input_ready = 1'b0;

    for (int i = 0; i < 20 && sbQueue.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 16'(sbQueue.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
